// File: rtl/spi_flash_slave.sv
// SPI mode-0 read-only flash slave (cmd 0x03) backed by a preloadable 32-bit word array.
// Define SPI_FLASH_CONT_READ_EN to keep streaming bytes past the first 32 data bits.
module spi_flash_slave #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          spi_sck,
  input  logic          spi_ss,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  localparam logic [AW+1:0] BA_ONE = 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [2:0]    sck_q;
  logic [1:0]    ss_q, mosi_q, settle;
  logic          armed, rise, fall, ss_s, mosi_s;
  state_t        state;
  logic [5:0]    bit_cnt;
  logic [7:0]    cmd_sr, shreg, byte_buf, fetch_byte;
  logic [23:0]   addr_sr, addr_next;
  logic [AW+1:0] byte_addr, fetch_addr;
  logic [31:0]   fetch_word;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // armed only sets once the synchronizer has flushed its reset value, so a
  // transfer after reset needs a genuine ss high -> low.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_q  <= 3'b000;
      ss_q   <= 2'b11;
      mosi_q <= 2'b00;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      ss_q   <= {ss_q[0], spi_ss};
      mosi_q <= {mosi_q[0], spi_mosi};
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ss_q[1]);
    end
  end

  assign rise   = sck_q[1] & ~sck_q[2];
  assign fall   = ~sck_q[1] & sck_q[2];
  assign ss_s   = ss_q[1];
  assign mosi_s = mosi_q[1];

  always_comb begin
    addr_next  = {addr_sr[22:0], mosi_s};
    fetch_addr = (state == ADDR) ? addr_next[AW+1:0] : byte_addr;
    fetch_word = mem[fetch_addr[AW+1:2]];
    case (fetch_addr[1:0])
      2'd0:    fetch_byte = fetch_word[31:24];
      2'd1:    fetch_byte = fetch_word[23:16];
      2'd2:    fetch_byte = fetch_word[15:8];
      default: fetch_byte = fetch_word[7:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      spi_miso  <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      shreg     <= '0;
      byte_buf  <= '0;
      byte_addr <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (ss_s && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        spi_miso <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            spi_miso <= 1'b0;
            if (!ss_s && armed) begin
              state   <= CMD;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          CMD: if (rise) begin
            cmd_sr <= {cmd_sr[6:0], mosi_s};
            if (bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              if ({cmd_sr[6:0], mosi_s} == 8'h03) begin
                state <= ADDR;
              end else begin
                state   <= IGNORE;
                cmd_err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          ADDR: if (rise) begin
            addr_sr <= addr_next;
            if (bit_cnt == 6'd23) begin
              bit_cnt   <= '0;
              byte_buf  <= fetch_byte;
              byte_addr <= fetch_addr + BA_ONE;
              state     <= DATA;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          DATA: if (fall) begin
`ifndef SPI_FLASH_CONT_READ_EN
            if (bit_cnt == 6'd32) begin
              state    <= IGNORE;
              spi_miso <= 1'b0;
            end else
`endif
            begin
              if (bit_cnt[2:0] == 3'd0) begin
                spi_miso <= byte_buf[7];
                shreg    <= {byte_buf[6:0], 1'b0};
              end else begin
                spi_miso <= shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
              end
              // Prefetch the next byte while the last bit of this one goes out.
              if (bit_cnt[2:0] == 3'd7) begin
                byte_buf  <= fetch_byte;
                byte_addr <= byte_addr + BA_ONE;
              end
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          IGNORE: spi_miso <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: table of preload/read vectors plus abort, bad-command,
// wrap and reset sequences. Builds with or without SPI_FLASH_CONT_READ_EN.
`timescale 1ns/1ps
module tb_spi_flash_slave;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          spi_sck = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
  logic          spi_miso;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          busy, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  spi_flash_slave #(.DEPTH_WORDS(256), .AW(AW)) dut (
    .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (cmd_err) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clock);
    mem_we = 1'b1; mem_waddr = AW'(idx); mem_wdata = data;
    @(negedge clock);
    mem_we = 1'b0;
  endtask

  // Mode 0: drive MOSI while sck low, sample MISO just before the rising edge.
  task automatic shift_bits(input int n, input logic [95:0] tx,
                            output logic [95:0] rx, output logic busy_last);
    rx = '0;
    busy_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[n-1-i];
      #50;
      rx = {rx[94:0], spi_miso};
      busy_last = busy;
      spi_sck = 1'b1;
      #50;
      spi_sck = 1'b0;
    end
  endtask

  task automatic end_xfer(input string name);
    #50;
    spi_ss = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk({name, "_busy_drop"}, {31'd0, busy}, 32'd0);
    #200;
    @(negedge clock);
  endtask

  task automatic xfer(input string name, input int n, input logic [95:0] tx,
                      output logic [95:0] rx, output logic busy_last);
    @(negedge clock);
    spi_ss = 1'b0;
    #100;
    shift_bits(n, tx, rx, busy_last);
    end_xfer(name);
  endtask

  typedef struct {
    string       name;
    int          wa;
    logic [31:0] da;
    int          wb;
    logic [31:0] db;
    logic [23:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [95:0] rx;
  logic        bl;
  int          e0;

  initial begin
    vecs[0] = '{"rd_deadbeef", 5, 32'hDEADBEEF, 6, 32'h00000000, 24'h000014, 32'hDEADBEEF};
    vecs[1] = '{"rd_unaligned2", 5, 32'h11223344, 6, 32'h55667788, 24'h000016, 32'h33445566};
    vecs[2] = '{"rd_unaligned1", 5, 32'h11223344, 6, 32'h55667788, 24'h000015, 32'h22334455};
    vecs[3] = '{"rd_unaligned3", 5, 32'h11223344, 6, 32'h55667788, 24'h000017, 32'h44556677};
    vecs[4] = '{"rd_word0", 0, 32'hCAFEF00D, 1, 32'h00000000, 24'h000000, 32'hCAFEF00D};
    vecs[5] = '{"rd_high_addr", 5, 32'hDEADBEEF, 6, 32'h00000000, 24'hFF0014, 32'hDEADBEEF};

    repeat (3) @(negedge clock);
    chk("reset_miso", {31'd0, spi_miso}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_cmd_err", {31'd0, cmd_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].wa, vecs[v].da);
      preload(vecs[v].wb, vecs[v].db);
      e0 = err_pulses;
      xfer(vecs[v].name, 64, {32'd0, 8'h03, vecs[v].addr, 32'd0}, rx, bl);
      chk({vecs[v].name, "_data"}, rx[31:0], vecs[v].exp);
      chk({vecs[v].name, "_hdr_miso0"}, rx[63:32], 32'd0);
      chk({vecs[v].name, "_busy"}, {31'd0, bl}, 32'd1);
      chk({vecs[v].name, "_no_err"}, err_pulses - e0, 32'd0);
    end

    // Unsupported command: one error pulse, MISO silent, parked busy in IGNORE.
    e0 = err_pulses;
    xfer("bad_cmd", 64, {32'd0, 8'h0B, 24'h000014, 32'hFFFFFFFF}, rx, bl);
    chk("bad_cmd_err", err_pulses - e0, 32'd1);
    chk("bad_cmd_miso_hi", rx[63:32], 32'd0);
    chk("bad_cmd_miso_lo", rx[31:0], 32'd0);
    chk("bad_cmd_busy", {31'd0, bl}, 32'd1);

    // Abort after 20 address bits, then a clean read.
    preload(0, 32'hCAFEF00D);
    xfer("abort", 28, {68'd0, 8'h03, 20'hFFFFF}, rx, bl);
    xfer("after_abort", 64, {32'd0, 8'h03, 24'h000000, 32'd0}, rx, bl);
    chk("after_abort_data", rx[31:0], 32'hCAFEF00D);

    // Wrap from the last word back to word 0.
    preload(255, 32'hA1B2C3D4);
    preload(0, 32'h01020304);
    xfer("wrap", 96, {8'h03, 24'h0003FE, 64'd0}, rx, bl);
    chk("wrap_first", rx[63:32], 32'hC3D40102);
`ifdef SPI_FLASH_CONT_READ_EN
    chk("wrap_second", {16'd0, rx[31:16]}, 32'h00000304);
`else
    chk("wrap_second", rx[31:0], 32'h00000000);
`endif

    // Reset mid-DATA, then ss held low with sck toggling must stay idle.
    preload(5, 32'hDEADBEEF);
    @(negedge clock);
    spi_ss = 1'b0;
    #100;
    shift_bits(37, {59'd0, 8'h03, 24'h000014, 5'd0}, rx, bl);
    chk("pre_reset_busy", {31'd0, bl}, 32'd1);
    chk("pre_reset_bits", {27'd0, rx[4:0]}, 32'h0000001B);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midreset_miso", {31'd0, spi_miso}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #100;
    shift_bits(16, {80'd0, 16'hFFFF}, rx, bl);
    chk("held_ss_busy", {31'd0, bl}, 32'd0);
    chk("held_ss_miso", rx[31:0], 32'd0);
    end_xfer("held_ss");
    xfer("after_reset", 64, {32'd0, 8'h03, 24'h000014, 32'd0}, rx, bl);
    chk("after_reset_data", rx[31:0], 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_flash_slave.md
SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as listed in REQ-002 and REQ-003.
REQ-002 DEPTH_WORDS, 256, number of 32-bit words in the internal flash array (power of two).
REQ-003 AW, 8, word-address width, equal to log2(DEPTH_WORDS).
REQ-004 Ports (name  direction  width  meaning) SHALL be as listed in REQ-005 to REQ-013; there is one clock, and reset is synchronous and active-high.
REQ-005 clock  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 spi_sck  input  1  SPI clock from master, idle low, frequency at most clock/4.
REQ-008 spi_ss  input  1  chip select, active low.
REQ-009 spi_mosi  input  1  serial data from master.
REQ-010 spi_miso  output  1  serial data to master.
REQ-011 mem_we  input  1  preload write strobe.
REQ-012 mem_waddr / mem_wdata  input  AW / 32  preload word address and data.
REQ-013 busy / cmd_err  output  1 / 1  transaction active; one-cycle pulse on an unsupported command.

Function
REQ-014 spi_sck, spi_ss and spi_mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sck only.
REQ-015 MOSI SHALL be sampled on a detected sck rising edge, and MISO SHALL be updated on a detected sck falling edge, MSB first (SPI mode 0).
REQ-016 The FSM states SHALL be IDLE, CMD, ADDR, DATA and IGNORE, with a 6-bit bit counter.
REQ-017 IDLE->CMD SHALL occur when synchronized ss is low; the bit counter clears on entry.
REQ-018 CMD: after 8 sampled bits, command 0x03 SHALL go to ADDR; any other value SHALL go to IGNORE and pulse cmd_err for 1 cycle.
REQ-019 ADDR: after 24 sampled bits, the byte address SHALL be latched and the state SHALL go to DATA.
REQ-020 DATA: the first data bit SHALL be on MISO after the first sck falling edge following the 24th address bit.
REQ-021 DATA SHALL stream 32 bits consisting of 4 bytes from consecutive byte addresses.
REQ-022 Byte mapping: byte address A SHALL select word A[AW+1:2], lane A[1:0]; lane 0 = bits[31:24] and lane 3 = bits[7:0] (big-endian).
REQ-023 Byte addresses SHALL wrap modulo DEPTH_WORDS*4; address bits above AW+1 SHALL be ignored.
REQ-024 In IGNORE, MISO SHALL be 0 and mosi SHALL be ignored until ss deasserts.
REQ-025 Synchronized ss high SHALL force IDLE from any state in the next cycle, drive MISO 0 and clear the counter; a partial transfer SHALL be discarded.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 MISO SHALL be 0 in IDLE, CMD and ADDR.
REQ-028 mem_we SHALL write mem_wdata to mem_waddr in 1 cycle, in any state.
REQ-029 A write to the word currently being shifted SHALL take effect at the next byte fetch; the byte in flight SHALL be unchanged.
REQ-030 The next byte SHALL be fetched from the array on the falling edge that shifts the last bit of the current byte (registered byte buffer, 0 extra sck cycles).

Reset
REQ-031 On reset the state SHALL be IDLE and spi_miso, busy, cmd_err, the counter, address and shift registers SHALL be 0.
REQ-032 Synchronizer flops SHALL reset to sck=0, ss=1, mosi=0.
REQ-033 Array contents SHALL be unaffected by reset.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer; after release, a new transfer SHALL require ss to go high and then low again.

Configuration
REQ-035 SPI_FLASH_CONT_READ_EN defined: DATA SHALL continue past 32 bits, streaming incrementing (wrapping) bytes until ss deasserts.
REQ-036 SPI_FLASH_CONT_READ_EN undefined: after 32 data bits the FSM SHALL enter IGNORE with MISO 0.

Verification
REQ-037 Preload word 5 = 0xDEADBEEF; 64-bit transfer cmd 0x03, addr 0x000014 -> MISO data bits read 0xDEADBEEF; busy falls within 3 cycles of ss high.
REQ-038 Preload word 5 = 0x11223344 and word 6 = 0x55667788; addr 0x000016 -> data 0x33445566.
REQ-039 Command 0x0B -> cmd_err pulses once, MISO stays 0 for the remaining 56 bits, state IGNORE, then IDLE after ss high.
REQ-040 ss raised after 20 address bits, then a full read of addr 0x000000 (word 0 = 0xCAFEF00D) -> 0xCAFEF00D, with no residue from the aborted transfer.
REQ-041 Preload the last word = 0xA1B2C3D4 and word 0 = 0x01020304; addr 0x0003FE, 96-bit transfer -> with SPI_FLASH_CONT_READ_EN: 0xC3D40102 then 0x0304xxxx; without it: 0xC3D40102 then 0x00000000.
REQ-042 Reset pulsed mid-DATA -> MISO 0 and busy 0 next cycle; ss held low with sck toggling keeps the FSM in IDLE.
